// File: rtl/scramble_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// scramble_sequencer_pkg
// Shared game-wide definitions for the scramble sequencer: FSM state
// encodings, the one-hot row/column decode constants and the decode helper.
// ---------------------------------------------------------------------------
package scramble_sequencer_pkg;

  // Scramble FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_FIRE   = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // One-hot row/column select for index 0..3
  localparam logic [3:0] OH_SEL0 = 4'b0001;
  localparam logic [3:0] OH_SEL1 = 4'b0010;
  localparam logic [3:0] OH_SEL2 = 4'b0100;
  localparam logic [3:0] OH_SEL3 = 4'b1000;
  localparam logic [3:0] OH_NONE = 4'b0000;

  // Width of the move and gap counters
  localparam int unsigned CNT_W = 32'd8;

  // Map a 2-bit index to its one-hot select; never multi-hot.
  function automatic logic [3:0] decode_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    case (idx)
      2'b00:   oh = OH_SEL0;
      2'b01:   oh = OH_SEL1;
      2'b10:   oh = OH_SEL2;
      2'b11:   oh = OH_SEL3;
      default: oh = OH_NONE;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/scramble_sequencer_generic_input.sv
// ---------------------------------------------------------------------------
// generic_input
// Registers a level input and reports its rising edge.
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   din    : debounced input level
//   din_q  : din delayed by one clock
//   rise   : high for one cycle when din goes low -> high
// A level that is already high when reset is released is not reported as
// an edge: the armed flag keeps rise low for the first post-reset cycle,
// by which time din_q has caught up with the input.
// ---------------------------------------------------------------------------
module generic_input (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic din_q,
  output logic rise
);

  logic din_q_r;
  logic armed_r;

  // Delay register and post-reset arming flag
  always_ff @(posedge clk) begin
    if (reset) begin
      din_q_r <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      din_q_r <= din;
      armed_r <= 1'b1;
    end
  end

  assign din_q = din_q_r;
  assign rise  = din & ~din_q_r & armed_r;

endmodule

// File: rtl/scramble_sequencer.sv
// ---------------------------------------------------------------------------
// scramble_sequencer
// Runs NUM_MOVES random row/column moves on the cell array after a press of
// the scramble button, leaving GAP_CYCLES idle cycles after each move.
//   clk          : system clock
//   reset        : synchronous, active-high reset (aborts a running scramble)
//   scramble_btn : debounced button level (rising edge starts a scramble)
//   random_num   : free-running random value; [2] row/column, [1:0] index
//   active       : high while a scramble is in progress
//   fire         : single-cycle move strobe to the cell array
//   x_nRow       : 0 = row move, 1 = column move (valid with fire)
//   row_column   : one-hot row/column select (valid with fire)
//   done         : single-cycle pulse when a scramble completes
//   moves_left   : moves not yet fired in the current scramble
// ---------------------------------------------------------------------------
module scramble_sequencer #(
  parameter int unsigned NUM_MOVES  = 32'd16,
  parameter int unsigned GAP_CYCLES = 32'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scramble_btn,
  input  logic [2:0] random_num,
  output logic       active,
  output logic       fire,
  output logic       x_nRow,
  output logic [3:0] row_column,
  output logic       done,
  output logic [7:0] moves_left
);

  import scramble_sequencer_pkg::*;

  localparam logic [CNT_W-1:0] MOVES_LOAD = CNT_W'(NUM_MOVES);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES);

  state_t           state_r;
  state_t           next_state_s;
  logic             btn_q_s;
  logic             btn_rise_s;
  logic [CNT_W-1:0] moves_left_r;
  logic [CNT_W-1:0] gap_cnt_r;
  logic             x_nrow_r;
  logic [3:0]       row_column_r;
  logic             active_s;
  logic             fire_s;
  logic             done_s;
  logic             active_r;
  logic             fire_r;
  logic             done_r;

  generic_input u_btn_edge (
    .clk   (clk),
    .reset (reset),
    .din   (scramble_btn),
    .din_q (btn_q_s),
    .rise  (btn_rise_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; button edges only matter in IDLE
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (btn_rise_s) begin
          next_state_s = ST_SELECT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SELECT: next_state_s = ST_FIRE;
      ST_FIRE:   next_state_s = ST_GAP;
      ST_GAP: begin
        // gap_cnt_r == 1 marks the last gap cycle
        if (gap_cnt_r <= CNT_W'(1)) begin
          if (moves_left_r != CNT_W'(0)) begin
            next_state_s = ST_SELECT;
          end else begin
            next_state_s = ST_DONE;
          end
        end else begin
          next_state_s = ST_GAP;
        end
      end
      ST_DONE:   next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the registered outputs line up
  // with the state they describe
  always_comb begin
    active_s = 1'b0;
    fire_s   = 1'b0;
    done_s   = 1'b0;
    case (next_state_s)
      ST_SELECT: active_s = 1'b1;
      ST_FIRE: begin
        active_s = 1'b1;
        fire_s   = 1'b1;
      end
      ST_GAP:    active_s = 1'b1;
      ST_DONE:   done_s   = 1'b1;
      default: begin
        active_s = 1'b0;
        fire_s   = 1'b0;
        done_s   = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      active_r <= 1'b0;
      fire_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      active_r <= active_s;
      fire_r   <= fire_s;
      done_r   <= done_s;
    end
  end

  // Move counter: loaded on a start, decremented once per FIRE
  always_ff @(posedge clk) begin
    if (reset) begin
      moves_left_r <= CNT_W'(0);
    end else if ((state_r == ST_IDLE) && btn_rise_s) begin
      moves_left_r <= MOVES_LOAD;
    end else if ((state_r == ST_FIRE) && (moves_left_r != CNT_W'(0))) begin
      moves_left_r <= moves_left_r - CNT_W'(1);
    end else begin
      moves_left_r <= moves_left_r;
    end
  end

  // Gap down-counter: loaded in FIRE, counts the GAP cycles down to zero
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt_r <= CNT_W'(0);
    end else if (state_r == ST_FIRE) begin
      gap_cnt_r <= GAP_LOAD;
    end else if ((state_r == ST_GAP) && (gap_cnt_r != CNT_W'(0))) begin
      gap_cnt_r <= gap_cnt_r - CNT_W'(1);
    end else begin
      gap_cnt_r <= CNT_W'(0);
    end
  end

  // Move select latch: sampled in SELECT, held through FIRE and GAP
  always_ff @(posedge clk) begin
    if (reset) begin
      x_nrow_r     <= 1'b0;
      row_column_r <= OH_NONE;
    end else if (state_r == ST_SELECT) begin
      x_nrow_r     <= random_num[2];
      row_column_r <= decode_onehot(random_num[1:0]);
    end else begin
      x_nrow_r     <= x_nrow_r;
      row_column_r <= row_column_r;
    end
  end

  assign active     = active_r;
  assign fire       = fire_r;
  assign done       = done_r;
  assign x_nRow     = x_nrow_r;
  assign row_column = row_column_r;
  assign moves_left = moves_left_r;

endmodule

// File: tb/tb_scramble_sequencer.sv
// ---------------------------------------------------------------------------
// tb_scramble_sequencer
// Scoreboard bench: stimulus pushes expected events (active rise, fire with
// its cycle/select/moves_left, done cycle) into queues; negedge monitors pop
// and compare whenever the DUTs present an event. dut1 runs NUM_MOVES=4,
// GAP_CYCLES=2; dut2 runs the NUM_MOVES=1, GAP_CYCLES=1 boundary.
// ---------------------------------------------------------------------------
module tb_scramble_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       reset1, btn1, act1, fire1, xn1, done1;
  logic [2:0] rnd1;
  logic [3:0] rc1;
  logic [7:0] ml1;
  logic       reset2, btn2, act2, fire2, xn2, done2;
  logic [2:0] rnd2;
  logic [3:0] rc2;
  logic [7:0] ml2;

  scramble_sequencer #(.NUM_MOVES(4), .GAP_CYCLES(2)) dut1 (
    .clk(clk), .reset(reset1), .scramble_btn(btn1), .random_num(rnd1),
    .active(act1), .fire(fire1), .x_nRow(xn1), .row_column(rc1),
    .done(done1), .moves_left(ml1)
  );

  scramble_sequencer #(.NUM_MOVES(1), .GAP_CYCLES(1)) dut2 (
    .clk(clk), .reset(reset2), .scramble_btn(btn2), .random_num(rnd2),
    .active(act2), .fire(fire2), .x_nRow(xn2), .row_column(rc2),
    .done(done2), .moves_left(ml2)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Expected fire = {cycle[15:0], 3'b0, x_nRow, row_column, moves_left}
  logic [31:0] f1_q[$];
  logic [31:0] f2_q[$];
  int          d1_q[$];
  int          d2_q[$];
  int          a1_q[$];
  int          a2_q[$];
  logic        act1_p = 1'b0;
  logic        act2_p = 1'b0;

  logic [3:0] oh_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  task automatic chk(input string nm, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, actual, expected, cyc);
    end
  endtask

  task automatic unexpected(input string nm);
    n_vec++;
    n_miss++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask

  // Scoreboard monitor for dut1
  always @(negedge clk) begin
    if (fire1 === 1'b1) begin
      if (f1_q.size() == 0) unexpected("fire1");
      else chk("fire1", {16'(cyc), 3'b000, xn1, rc1, ml1}, f1_q.pop_front());
    end
    if (done1 === 1'b1) begin
      if (d1_q.size() == 0) unexpected("done1");
      else chk("done1", 32'(cyc), 32'(d1_q.pop_front()));
    end
    if (act1 === 1'b1 && act1_p !== 1'b1) begin
      if (a1_q.size() == 0) unexpected("active1");
      else chk("active1", 32'(cyc), 32'(a1_q.pop_front()));
    end
    act1_p <= act1;
  end

  // Scoreboard monitor for dut2
  always @(negedge clk) begin
    if (fire2 === 1'b1) begin
      if (f2_q.size() == 0) unexpected("fire2");
      else chk("fire2", {16'(cyc), 3'b000, xn2, rc2, ml2}, f2_q.pop_front());
    end
    if (done2 === 1'b1) begin
      if (d2_q.size() == 0) unexpected("done2");
      else chk("done2", 32'(cyc), 32'(d2_q.pop_front()));
    end
    if (act2 === 1'b1 && act2_p !== 1'b1) begin
      if (a2_q.size() == 0) unexpected("active2");
      else chk("active2", 32'(cyc), 32'(a2_q.pop_front()));
    end
    act2_p <= act2;
  end

  // dut1 expectations for a press at cycle t; move k uses vals[3k+:3]
  task automatic push1(input int t, input logic [11:0] vals, input int nfires, input bit with_done);
    logic [2:0] v;
    a1_q.push_back(t + 1);
    for (int k = 0; k < nfires; k++) begin
      v = vals[3*k +: 3];
      f1_q.push_back({16'(t + 2 + 4*k), 3'b000, v[2], oh_tab[v[1:0]], 8'(4 - k)});
    end
    if (with_done) d1_q.push_back(t + 17);
  endtask

  // Raise dut1 button just after a posedge; returns that cycle
  task automatic raise1(output int t);
    @(posedge clk); #1;
    t = cyc;
    btn1 = 1'b1;
  endtask

  task automatic drop1();
    @(posedge clk); #1;
    btn1 = 1'b0;
  endtask

  function automatic int pending();
    return f1_q.size() + f2_q.size() + d1_q.size() + d2_q.size() + a1_q.size() + a2_q.size();
  endfunction

  // Wait (bounded) until all expected events have been observed
  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (pending() == 0) break;
    end
    chk("drain_pending", 32'(pending()), 32'd0);
  endtask

  // Wait (bounded) for the next dut1 fire
  task automatic wait_fire1(input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (fire1 === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_miss++;
      $display("FAIL wait_fire1: no fire within %0d cycles", budget);
    end
  endtask

  int t;

  initial begin
    reset1 = 1'b1; btn1 = 1'b0; rnd1 = 3'b000;
    reset2 = 1'b1; btn2 = 1'b0; rnd2 = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    reset1 = 1'b0;
    reset2 = 1'b0;

    // Idle after reset: every output stays zero
    repeat (20) begin
      @(negedge clk);
      chk("idle_outputs", {17'd0, act1, fire1, done1, xn1, rc1, ml1}, 32'd0);
    end

    // Basic scramble, random_num = 110 -> column, 0100
    rnd1 = 3'b110;
    raise1(t);
    push1(t, {3'b110, 3'b110, 3'b110, 3'b110}, 4, 1'b1);
    drop1();
    wait_drain(40);
    @(negedge clk);
    chk("moves_left_end", 32'(ml1), 32'd0);

    // Decode sweep: values 0..3 then 4..7, one per move
    for (int s = 0; s < 2; s++) begin
      rnd1 = 3'(4*s);
      raise1(t);
      push1(t, {3'(4*s + 3), 3'(4*s + 2), 3'(4*s + 1), 3'(4*s)}, 4, 1'b1);
      drop1();
      for (int k = 0; k < 3; k++) begin
        wait_fire1(10);
        rnd1 = 3'(4*s + k + 1);
      end
      wait_drain(40);
      repeat (3) @(posedge clk);
    end

    // Presses during a scramble are ignored; held button gives no rerun
    rnd1 = 3'b001;
    raise1(t);
    push1(t, {3'b001, 3'b001, 3'b001, 3'b001}, 4, 1'b1);
    repeat (4) begin
      repeat (3) @(posedge clk);
      #1;
      btn1 = ~btn1;
    end
    wait_drain(40);
    repeat (25) @(negedge clk);
    chk("held_btn_idle", {31'd0, act1}, 32'd0);
    btn1 = 1'b0;
    repeat (3) @(posedge clk);

    // Abort: reset between the 2nd and 3rd fire
    rnd1 = 3'b011;
    raise1(t);
    push1(t, {3'b011, 3'b011, 3'b011, 3'b011}, 2, 1'b0);
    drop1();
    repeat (7) @(posedge clk);
    #1;
    reset1 = 1'b1;
    @(posedge clk); #1;
    reset1 = 1'b0;
    @(negedge clk);
    chk("abort_state", {21'd0, act1, fire1, done1, rc1, ml1}, 32'd0);
    repeat (20) @(negedge clk);
    chk("abort_pending", 32'(pending()), 32'd0);

    // Full scramble after the abort
    rnd1 = 3'b100;
    raise1(t);
    push1(t, {3'b100, 3'b100, 3'b100, 3'b100}, 4, 1'b1);
    drop1();
    wait_drain(40);

    // Button high across reset release: no scramble until it re-rises
    @(posedge clk); #1;
    reset1 = 1'b1;
    btn1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset1 = 1'b0;
    repeat (12) @(negedge clk);
    chk("btn_high_reset", {31'd0, act1}, 32'd0);
    btn1 = 1'b0;
    repeat (3) @(posedge clk);

    // Boundary on dut2: NUM_MOVES=1, GAP_CYCLES=1
    rnd2 = 3'b101;
    @(posedge clk); #1;
    t = cyc;
    btn2 = 1'b1;
    a2_q.push_back(t + 1);
    f2_q.push_back({16'(t + 2), 3'b000, 1'b1, 4'b0010, 8'd1});
    d2_q.push_back(t + 4);
    @(posedge clk); #1;
    btn2 = 1'b0;
    wait_drain(20);
    repeat (10) @(negedge clk);

    chk("final_pending", 32'(pending()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
